baud_gen_frac: RTL and testbench
================================

// Module: baud_gen_frac
// PURPOSE
//  Runtime-programmable fractional baud-rate generator for the RS-232 TX/RX path.
//  Emits an oversample tick (ovs_tick_o) and a bit tick (bit_tick_o, every OVS ovs ticks).
//  Divisor = div_int + div_frac/2^FRAC_W clocks per ovs tick.
//  sync_i re-phases the generator to a start-bit edge; the RX FSM uses it with half_i=1
//  to sample at mid-bit. TX uses bit_tick_o.
// PARAMETERS
//  DIV_W        16   width of integer divisor
//  FRAC_W       4    width of fractional divisor / phase accumulator
//  OVS          16   ovs ticks per bit tick; >=2, any integer
//  DEF_DIV_INT  27   integer divisor loaded at reset; >=1
//  DEF_DIV_FRAC 0    fractional divisor loaded at reset
// PORTS
//  clk_i       in   1       system clock
//  rst_i       in   1       synchronous reset, active-high
//  en_i        in   1       1 = count; 0 = freeze all counters, no ticks
//  div_int_i   in   DIV_W   new integer divisor; 0 is treated as 1
//  div_frac_i  in   FRAC_W  new fractional divisor
//  div_load_i  in   1       1-cycle strobe: capture div_int_i/div_frac_i into pending regs
//  sync_i      in   1       1-cycle strobe: restart phase
//  half_i      in   1       sampled with sync_i: 1 = first bit tick after OVS/2 ovs ticks
//  ovs_tick_o  out  1       1-cycle oversample tick
//  bit_tick_o  out  1       1-cycle bit tick, coincident with an ovs_tick_o
//  pend_o      out  1       divisor update pending, not yet applied
// BEHAVIOUR
//  - State: cnt[DIV_W] down-counter, acc[FRAC_W], ovs_cnt[clog2(OVS)], active div, pending div, pend.
//  - Reset (rst_i=1 at clk edge): active div <= DEF_*; cnt <= DEF_DIV_INT-1; acc, ovs_cnt,
//    pend <= 0. While rst_i=1, all outputs are 0.
//  - ovs_tick_o = en_i & (cnt==0) & ~sync_i & ~rst_i. Decoded from registers, so there is
//    no added latency.
//  - If en_i=1, sync_i=0 and cnt!=0: cnt <= cnt-1.
//  - On ovs tick:
//    - {carry,acc} <= acc + frac_eff
//    - cnt <= int_eff - 1 + carry  (period is int_eff or int_eff+1 clocks)
//    - ovs_cnt <= (ovs_cnt==OVS-1) ? 0 : ovs_cnt+1
//  - bit_tick_o = ovs_tick_o & (ovs_cnt==OVS-1).
//  - Effective divisor (int_eff/frac_eff):
//    - If pend=1 at a tick, the pending values are used for that reload and become the
//      active divisor; pend <= 0.
//    - Otherwise the active divisor is used.
//    - A value of 0 in int_eff is used as 1.
//  - div_load_i: pending <= inputs, pend <= 1.
//    - If en_i=0, the value is applied directly to the active divisor and pend stays 0.
//    - A second load before application overwrites the pending value.
//  - sync_i=1 has priority over counting and ticks; no tick is generated in that cycle.
//    - Applies pending divisor (if any); acc <= 0; cnt <= int_eff-1.
//    - ovs_cnt <= half_i ? OVS/2 : 0.
//    - Counting resumes the next cycle.
//  - Simultaneous sync_i and div_load_i: the new inputs are applied immediately with the
//    sync; pend=0.
//  - Simultaneous div_load_i and a tick: the tick reloads with the old/pending value; the
//    new value goes pending.
//  - en_i=0 freezes cnt/acc/ovs_cnt; on re-enable, counting continues exactly where it stopped.
//  - Reset mid-operation aborts everything; no tick in the reset cycle.
//  - Rate: average bit period = OVS*(div_int + div_frac/2^FRAC_W) clocks.
// STRUCTURE
//  - Shared header uart_defs.vh: OVS default; a clocks-per-ovs macro computed from clk freq
//    and baud (integer and fractional parts); DIV_W/FRAC_W defaults, so TX, RX and the
//    register block agree.
//  - One sub-module: frac_accum (FRAC_W adder + acc register, outputs carry, clears on sync).
//  - cnt and ovs_cnt logic stay in the top.
// TESTING
//  Default params except where a scenario says otherwise.
//  1. Reset, en=1, DEF_DIV_INT=3, frac=0 -> ovs tick every 3 clks; first tick 3 clks after
//     reset release; bit tick every 48 clks.
//  2. div_int=3, frac=8 -> ovs periods 3,3,4,3,4,...; 16 ovs ticks span 56 clks; bit period
//     56 steady.
//  3. div_int=0 -> ovs tick every clock, bit tick every 16 clocks; div_int=1 gives the same.
//  4. Mid-run div_load_i 3->5 (en=1) -> pend_o=1 until next ovs tick; the following period
//     is 5 clks; pend_o=0 after that tick.
//  5. sync_i with half_i=1, div_int=2 -> no tick in sync cycle; first bit tick after 8 ovs
//     ticks (16 clks), then every 32.
//  6. en_i low for 10 clks mid-period, then rst_i mid-run ->
//     - en_i low: period stretched by exactly 10, no ticks while low.
//     - rst_i: outputs 0, DEF divisor restored, pend_o=0.

Source files
------------

// File: rtl/baud_gen_frac_pkg.sv
// Shared defaults and helpers for the fractional baud generator, so TX, RX and
// the register block agree on widths, oversampling and divisor arithmetic.
package baud_gen_frac_pkg;

  localparam int DIV_W_DEF   = 16;
  localparam int FRAC_W_DEF  = 4;
  localparam int OVS_DEF     = 16;
  localparam int DIV_INT_DEF = 27;

  // Where the divisor for a reload comes from.
  typedef enum logic [1:0] {
    SRC_ACTIVE  = 2'd0,
    SRC_PENDING = 2'd1,
    SRC_INPUT   = 2'd2
  } div_src_e;

  // Integer part of clocks per oversample tick for a given clock and baud rate.
  function automatic longint unsigned clk_per_ovs_int(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs
  );
    return clk_hz / (baud * ovs);
  endfunction

  // Fractional part, in units of 1/2^frac_w clock.
  function automatic longint unsigned clk_per_ovs_frac(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs,
    input int unsigned     frac_w
  );
    longint unsigned scaled;
    scaled = (clk_hz << frac_w) / (baud * ovs);
    return scaled & ((64'd1 << frac_w) - 64'd1);
  endfunction

endpackage

// File: rtl/baud_gen_frac_frac_accum.sv
// Fractional phase accumulator: adds the fractional divisor on every ovs tick and
// reports the carry that stretches the next period by one clock.
module frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum     = {1'b0, acc} + {1'b0, frac_i};
  assign carry_o = sum[FRAC_W];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc <= '0;
    end else if (step_i) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Runtime-programmable fractional baud generator: ovs tick every div_int+div_frac/2^FRAC_W
// clocks on average, bit tick every OVS ovs ticks, with re-phasing for start-bit sync.
module baud_gen_frac
  import baud_gen_frac_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVS          = OVS_DEF,
  parameter int DEF_DIV_INT  = DIV_INT_DEF,
  parameter int DEF_DIV_FRAC = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  input  logic              sync_i,
  input  logic              half_i,
  output logic              ovs_tick_o,
  output logic              bit_tick_o,
  output logic              pend_o
);

  localparam int OVS_CW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OVS_CW-1:0] OVS_LAST = OVS_CW'(OVS - 1);
  localparam logic [OVS_CW-1:0] OVS_HALF = OVS_CW'(OVS / 2);
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(DEF_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_DIV_FRAC);

  logic [DIV_W-1:0]  cnt;
  logic [OVS_CW-1:0] ovs_cnt;
  logic [DIV_W-1:0]  act_int, pnd_int, int_sel, int_eff;
  logic [FRAC_W-1:0] act_frac, pnd_frac, frac_sel;
  logic              pend;
  logic              tick;
  logic              carry;
  div_src_e          src;

  assign tick       = en_i & (cnt == '0) & ~sync_i & ~rst_i;
  assign ovs_tick_o = tick;
  assign bit_tick_o = tick & (ovs_cnt == OVS_LAST);
  assign pend_o     = pend & ~rst_i;

  // A load coinciding with sync bypasses the pending stage entirely.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
    src      = SRC_ACTIVE;
    int_sel  = act_int;
    frac_sel = act_frac;
    if (sync_i && div_load_i) begin
      src = SRC_INPUT;
    end else if (pend) begin
      src = SRC_PENDING;
    end
    case (src)
      SRC_INPUT: begin
        int_sel  = div_int_i;
        frac_sel = div_frac_i;
      end
      SRC_PENDING: begin
        int_sel  = pnd_int;
        frac_sel = pnd_frac;
      end
      default: ;
    endcase
  end

  assign int_eff = (int_sel == '0) ? DIV_W'(1) : int_sel;

  frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (sync_i),
    .step_i  (tick),
    .frac_i  (frac_sel),
    .carry_o (carry)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      cnt      <= RST_INT - DIV_W'(1);
      ovs_cnt  <= '0;
      act_int  <= RST_INT;
      act_frac <= RST_FRAC;
      pnd_int  <= '0;
      pnd_frac <= '0;
      pend     <= 1'b0;
    end else if (sync_i) begin
      cnt      <= int_eff - DIV_W'(1);
      ovs_cnt  <= half_i ? OVS_HALF : '0;
      act_int  <= int_sel;
      act_frac <= frac_sel;
      pend     <= 1'b0;
    end else begin
      if (tick) begin
        cnt      <= int_eff - DIV_W'(1) + DIV_W'(carry);
        ovs_cnt  <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_CW'(1);
        act_int  <= int_sel;
        act_frac <= frac_sel;
        pend     <= 1'b0;
      end else if (en_i && cnt != '0) begin
        cnt <= cnt - DIV_W'(1);
      end
      // Later assignments win: a load in a tick cycle leaves the new value pending.
      if (div_load_i) begin
        if (!en_i) begin
          act_int  <= div_int_i;
          act_frac <= div_frac_i;
          pend     <= 1'b0;
        end else begin
          pnd_int  <= div_int_i;
          pnd_frac <= div_frac_i;
          pend     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: directed scenarios plus random traffic, checked
// against a period-level reference model of the fractional divider.
module tb_baud_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
  localparam int DEF_I  = 3;
  localparam int FSCALE = 1 << FRAC_W;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              en_i = 1'b0;
  logic [DIV_W-1:0]  div_int_i = '0;
  logic [FRAC_W-1:0] div_frac_i = '0;
  logic              div_load_i = 1'b0;
  logic              sync_i = 1'b0;
  logic              half_i = 1'b0;
  logic              ovs_tick_o, bit_tick_o, pend_o;

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_DIV_INT(DEF_I), .DEF_DIV_FRAC(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .div_int_i(div_int_i), .div_frac_i(div_frac_i),
    .div_load_i(div_load_i), .sync_i(sync_i), .half_i(half_i),
    .ovs_tick_o(ovs_tick_o), .bit_tick_o(bit_tick_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] outs;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   ovs_times[$];
  int   bit_times[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: divisor bookkeeping plus "clocks left until the next tick",
  // with the fractional remainder carried as a phase in 1/2^FRAC_W clock units.
  int m_int, m_frac, p_int, p_frac, m_wait, m_phase, m_ovs;
  bit m_pend;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_int = DEF_I; m_frac = 0; p_int = 0; p_frac = 0;
    m_pend = 0; m_wait = DEF_I - 1; m_phase = 0; m_ovs = 0;
  endtask

  task automatic cycle(input bit rst, input bit en, input bit sync, input bit half,
                       input bit load, input int di, input int df);
    exp_t e;
    bit   t;
    int   ci, cf, s;
    @(negedge clk);
    rst_i = rst; en_i = en; sync_i = sync; half_i = half; div_load_i = load;
    div_int_i = di[DIV_W-1:0]; div_frac_i = df[FRAC_W-1:0];
    t = !rst && en && !sync && (m_wait == 0);
    e.outs = {t, t && (m_ovs == OVS - 1), !rst && m_pend};
    e.cyc  = cyc;
    sb.push_back(e);
    if (rst) begin
      model_reset();
    end else if (sync) begin
      if (load)        begin ci = di;    cf = df;     end
      else if (m_pend) begin ci = p_int; cf = p_frac; end
      else             begin ci = m_int; cf = m_frac; end
      m_int = ci; m_frac = cf; m_pend = 0; m_phase = 0;
      m_wait = eff(ci) - 1; m_ovs = half ? OVS / 2 : 0;
    end else begin
      if (t) begin
        if (m_pend) begin m_int = p_int; m_frac = p_frac; m_pend = 0; end
        s = m_phase + m_frac;
        m_wait  = eff(m_int) - 1 + s / FSCALE;
        m_phase = s % FSCALE;
        m_ovs   = (m_ovs + 1) % OVS;
      end else if (en && m_wait > 0) begin
        m_wait--;
      end
      if (load) begin
        if (!en) begin m_int = di; m_frac = df; m_pend = 0; end
        else     begin p_int = di; p_frac = df; m_pend = 1; end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic load_div(input int di, input int df);
    cycle(0, 1, 0, 0, 1, di, df);
  endtask

  task automatic drain();
    #3;
  endtask

  function automatic int first_after(input int q[$], input int c);
    foreach (q[i]) if (q[i] >= c) return q[i];
    return -100000;
  endfunction

  function automatic int last_before(input int q[$], input int c);
    int r = -100000;
    foreach (q[i]) if (q[i] < c) r = q[i];
    return r;
  endfunction

  function automatic int span(input int q[$], input int k);
    if (q.size() <= k) return -1;
    return q[q.size() - 1] - q[q.size() - 1 - k];
  endfunction

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("cycle %0d {ovs,bit,pend}", e.cyc),
              int'({ovs_tick_o, bit_tick_o, pend_o}), int'(e.outs));
        if (ovs_tick_o) ovs_times.push_back(e.cyc);
        if (bit_tick_o) bit_times.push_back(e.cyc);
      end
    end
  end

  initial begin
    int r, l, t1, t2, s, p;
    model_reset();

    // 1: defaults after reset
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    r = cyc;
    run(150);
    drain();
    check("s1 first ovs tick offset", first_after(ovs_times, r) - r, 2);
    check("s1 ovs period", span(ovs_times, 1), 3);
    check("s1 first bit tick offset", first_after(bit_times, r) - r, 47);
    check("s1 bit period", span(bit_times, 1), 48);

    // 2: fractional divisor 3 + 8/16
    load_div(3, 8);
    run(300);
    drain();
    check("s2 16 ovs span", span(ovs_times, 16), 56);
    check("s2 bit period", span(bit_times, 1), 56);

    // 3: zero and one integer divisors
    load_div(0, 0);
    run(100);
    drain();
    check("s3 div0 ovs period", span(ovs_times, 1), 1);
    check("s3 div0 bit period", span(bit_times, 1), 16);
    load_div(1, 0);
    run(100);
    drain();
    check("s3 div1 ovs period", span(ovs_times, 1), 1);
    check("s3 div1 bit period", span(bit_times, 1), 16);

    // 4: mid-period reload 3 -> 5
    load_div(3, 0);
    run(20);
    while (m_wait == 0) run(1);
    l = cyc;
    load_div(5, 0);
    run(30);
    drain();
    t1 = first_after(ovs_times, l + 1);
    t2 = first_after(ovs_times, t1 + 1);
    check("s4 period after reload", t2 - t1, 5);

    // 5: half-bit sync with div 2
    load_div(2, 0);
    run(10);
    s = cyc;
    cycle(0, 1, 1, 1, 0, 0, 0);
    run(100);
    drain();
    check("s5 first ovs after sync", first_after(ovs_times, s) - s, 2);
    t1 = first_after(bit_times, s);
    check("s5 first bit after sync", t1 - s, 16);
    check("s5 bit period", first_after(bit_times, t1 + 1) - t1, 32);

    // 6: enable gap, then reset mid-run with a pending load
    load_div(5, 0);
    run(20);
    while (m_wait < 2) run(1);
    p = cyc;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    run(20);
    drain();
    check("s6 stretched period",
          first_after(ovs_times, p) - last_before(ovs_times, p), 15);
    while (m_wait == 0) run(1);
    load_div(4, 1);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    r = cyc;
    run(30);
    drain();
    check("s6 first tick after reset", first_after(ovs_times, r) - r, 2);
    check("s6 default period restored", span(ovs_times, 1), 3);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit rr, ee, ss, hh, ll;
      rr = ($urandom_range(0, 199) == 0);
      ee = ($urandom_range(0, 9) != 0);
      ss = ($urandom_range(0, 49) == 0);
      hh = $urandom_range(0, 1);
      ll = ($urandom_range(0, 29) == 0);
      cycle(rr, ee, ss, hh, ll, $urandom_range(0, 5), $urandom_range(0, FSCALE - 1));
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #3;
    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
